// File: rtl/karatsuba_pkg.sv
// Shared constants for the sequential Karatsuba multiplier.
// FSM state encoding plus width helpers for the half-word datapath.
package karatsuba_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL_Z0  = 3'd1;
  localparam logic [2:0] S_MUL_Z2  = 3'd2;
  localparam logic [2:0] S_MUL_M   = 3'd3;
  localparam logic [2:0] S_COMBINE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int prod_w(input int h);
    return 2 * h;
  endfunction

  function automatic int m_w(input int h);
    return 2 * h + 2;
  endfunction

endpackage

// File: rtl/karatsuba_mul_seq_if.sv
// Operand/result handshake bundle for karatsuba_mul_seq.
// master drives in_valid/a/b/out_ready (and tc with KARATSUBA_SIGNED_EN).
interface karatsuba_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;
`ifdef KARATSUBA_SIGNED_EN
  logic               tc;

  modport master (
    output in_valid, a, b, tc, out_ready,
    input  in_ready, out_valid, p, busy
  );
  modport slave (
    input  in_valid, a, b, tc, out_ready,
    output in_ready, out_valid, p, busy
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
`endif
endinterface

// File: rtl/karatsuba_shared_mul.sv
// Combinational (HALF+1)x(HALF+1) unsigned multiply, reused 3x per op.
// Ports: x_i, y_i operands; p_o full 2*HALF+2 bit product.
module karatsuba_shared_mul #(
  parameter int HALF = 8
) (
  input  logic [HALF:0]     x_i,
  input  logic [HALF:0]     y_i,
  output logic [2*HALF+1:0] p_o
);

  assign p_o = x_i * y_i;

endmodule

// File: rtl/karatsuba_mul_seq.sv
// Multi-cycle Karatsuba multiplier: z0, z2, m on one shared multiplier.
// Ports: clk, rst (async, high), bus (slave handshake). KARATSUBA_SIGNED_EN adds tc.
module karatsuba_mul_seq
  import karatsuba_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter bit HOLD_ON_IDLE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  karatsuba_mul_seq_if.slave bus
);

  localparam int HALF = half_w(WIDTH);
  localparam int PW   = prod_w(HALF);
  localparam int MW   = m_w(HALF);
  localparam int W2   = 2 * WIDTH;

  logic [2:0]      state_q, state_d;
  logic [HALF-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [HALF:0]   sa_q, sb_q;
  logic [PW-1:0]   z0_q, z2_q;
  logic [MW-1:0]   m_q;
  logic [W2-1:0]   p_q;
  logic            ov_q;

  logic [WIDTH-1:0] opa, opb;
  logic [HALF:0]    mx, my;
  logic [MW-1:0]    mp;
  logic [MW-1:0]    z1;
  logic [W2-1:0]    prod, pres;
  logic             in_ready, accept, handoff;

  assign in_ready = (state_q == S_IDLE) ||
                    ((state_q == S_DONE) && bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign handoff  = ov_q & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.p         = p_q;
  assign bus.busy      = (state_q != S_IDLE);

`ifdef KARATSUBA_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitude of the most negative value still fits in WIDTH unsigned bits.
  always_comb begin
    opa   = bus.a;
    opb   = bus.b;
    neg_d = 1'b0;
    if (bus.tc) begin
      if (bus.a[WIDTH-1]) opa = -bus.a;
      if (bus.b[WIDTH-1]) opb = -bus.b;
      neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  assign pres = neg_q ? -prod : prod;
`else
  assign opa  = bus.a;
  assign opb  = bus.b;
  assign pres = prod;
`endif

  always_comb begin
    mx = sa_q;
    my = sb_q;
    case (state_q)
      S_MUL_Z0: begin
        mx = {1'b0, a0_q};
        my = {1'b0, b0_q};
      end
      S_MUL_Z2: begin
        mx = {1'b0, a1_q};
        my = {1'b0, b1_q};
      end
      default: ;
    endcase
  end

  karatsuba_shared_mul #(
    .HALF (HALF)
  ) u_mul (
    .x_i (mx),
    .y_i (my),
    .p_o (mp)
  );

  // m >= z0 + z2 always, so z1 never wraps.
  assign z1 = m_q - {2'b00, z0_q} - {2'b00, z2_q};

  assign prod = ({{(W2-PW){1'b0}}, z2_q} << WIDTH)
              + ({{(W2-MW){1'b0}}, z1}   << HALF)
              +  {{(W2-PW){1'b0}}, z0_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_MUL_Z0;
      S_MUL_Z0:  state_d = S_MUL_Z2;
      S_MUL_Z2:  state_d = S_MUL_M;
      S_MUL_M:   state_d = S_COMBINE;
      S_COMBINE: state_d = S_DONE;
      S_DONE:
        if (handoff) state_d = accept ? S_MUL_Z0 : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      m_q     <= '0;
      p_q     <= '0;
      ov_q    <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a0_q <= opa[HALF-1:0];
        a1_q <= opa[WIDTH-1:HALF];
        b0_q <= opb[HALF-1:0];
        b1_q <= opb[WIDTH-1:HALF];
        sa_q <= {1'b0, opa[HALF-1:0]} + {1'b0, opa[WIDTH-1:HALF]};
        sb_q <= {1'b0, opb[HALF-1:0]} + {1'b0, opb[WIDTH-1:HALF]};
`ifdef KARATSUBA_SIGNED_EN
        neg_q <= neg_d;
`endif
      end
      if (state_q == S_MUL_Z0) z0_q <= mp[PW-1:0];
      if (state_q == S_MUL_Z2) z2_q <= mp[PW-1:0];
      if (state_q == S_MUL_M)  m_q  <= mp;
      if (state_q == S_COMBINE) begin
        p_q  <= pres;
        ov_q <= 1'b1;
      end else if (handoff) begin
        ov_q <= 1'b0;
        if (!HOLD_ON_IDLE) p_q <= '0;
      end
    end
  end

endmodule

// File: doc/karatsuba_mul_seq.md
Name: karatsuba_mul_seq

Overview:
- Multi-cycle, area-reduced Karatsuba multiplier, parametrised in WIDTH.
- Uses one shared (HALF+1)x(HALF+1) multiplier three times per operation: z0, then z2, then m.
- Sequenced by a small FSM with valid/ready handshakes on both the input and output sides.
- Intended for datapaths where one full-width array multiplier is too large and 5-cycle throughput is acceptable.

Parameters:
- WIDTH, 16, operand width. Must be even and >= 4. HALF = WIDTH/2.
- HOLD_ON_IDLE, 1. 1 = p keeps its last result after handoff. 0 = p clears to 0 on handoff.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  p holds a completed product
- out_ready  in  1  consumer accepts p
- p  out  2*WIDTH  product
- busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, p=0, busy=0, all internal registers=0. in_ready=1 once rst deasserts.
- Reset asserted mid-operation aborts the operation immediately. No output is produced for the aborted operands.
- FSM states: IDLE, MUL_Z0, MUL_Z2, MUL_M, COMBINE, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (accept edge E0):
  - register a0/a1/b0/b1;
  - register sa=a0+a1 and sb=b0+b1, each HALF+1 bits;
  - go to MUL_Z0.
- MUL_Z0 -> MUL_Z2 -> MUL_M: one cycle each. The shared multiplier operand mux selects {0,a0}x{0,b0}, then {0,a1}x{0,b1}, then sa x sb. Each product is registered at the end of its cycle into z0, z2, m. z0 and z2 are 2*HALF bits; m is 2*HALF+2 bits.
- COMBINE: one cycle.
  - z1 = m - z0 - z2, computed in 2*HALF+2 bits. The result is never negative.
  - p <= (z2<<WIDTH) + (z1<<HALF) + z0, evaluated at 2*WIDTH bits with no truncation loss.
  - out_valid <= 1, go to DONE.
- Latency: out_valid rises at edge E4, 4 clocks after the accept edge.
- DONE: p and out_valid are held stable while out_ready=0, for unlimited backpressure.
  - On out_valid&out_ready: out_valid <= 0.
  - If in_valid is also high in that same cycle, accept the new operands (in_ready=1) and go directly to MUL_Z0. Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready only.
- Sustained throughput: one result per 5 cycles.
- Inputs are ignored outside the accept cycle. a and b may change freely after the accept edge.
- Zero operands and all-ones operands need no special case. Example: WIDTH=16, 0xFFFF*0xFFFF = 0xFFFE0001.

Optional Feature:
- Macro: KARATSUBA_SIGNED_EN.
- Defined:
  - Adds input port tc (1 bit), sampled at the accept edge.
  - tc=1: a and b are two's complement. Their magnitudes are registered as WIDTH-bit unsigned values (magnitude of the minimum value fits). The sign neg = a[MSB]^b[MSB] is registered.
  - COMBINE produces the unsigned product, then negates it when neg=1. Latency is unchanged.
  - tc=0: identical to the unsigned behaviour.
- Not defined: no tc port, no abs/negate logic, unsigned only.

Decomposition:
- Package karatsuba_pkg:
  - FSM state encoding constants;
  - localparam helpers for HALF, product width (2*HALF), and m width (2*HALF+2).
- One sub-module: karatsuba_shared_mul. It is a combinational (HALF+1)x(HALF+1) unsigned multiply, parametrised by HALF, so it can later be swapped for a recursive karatsuba_mul or a DSP wrapper.
- Operand mux, FSM, and combine adders stay in the top.

Test Plan:
- WIDTH=16: accept a=0xFFFF, b=0xFFFF.
  - p=0xFFFE0001; out_valid high exactly 4 cycles after the accept edge.
  - busy high from the edge after accept until handoff.
- Hold out_ready=0 for 10 cycles after out_valid rises with a=0x1234, b=0x5678.
  - p=0x06260060 stable and out_valid=1 throughout; in_ready=0.
- Back-to-back: assert in_valid with a=3, b=5 while DONE and out_ready=1.
  - New operands accepted in the handoff cycle; next p=15 exactly 5 cycles after the previous out_valid edge.
- Assert rst in MUL_Z2.
  - out_valid=0, p=0, busy=0 immediately.
  - After release, a=2, b=7 gives p=14 with the normal latency.
- WIDTH=32 and WIDTH=6: 1000 random operand pairs including 0, 1, and all-ones.
  - Every p equals the reference a*b.
  - Scoreboard order is preserved under random out_ready.
- With KARATSUBA_SIGNED_EN, WIDTH=16, tc=1:
  - 0xFFFF*0xFFFF gives p=0x00000001.
  - 0x8000*0x8000 gives p=0x40000000.
  - 0x8000*0x0001 gives p=0xFFFF8000.
  - With tc=0, 0xFFFF*0xFFFF gives p=0xFFFE0001.
